// File: rtl/udma_arb_pkg.sv
// udma_arb_pkg
//   Shared definitions for the uDMA TX read-request arbiter:
//   datasize encodings, the outstanding-FIFO entry layout and the
//   response size-mask helper.
//   Optional feature macro: UDMA_TX_ARB_ALIGN_EN (adds the byte-lane
//   offset field to the FIFO entry).
package udma_arb_pkg;

    localparam logic [1:0] DSIZE_BYTE    = 2'b00;
    localparam logic [1:0] DSIZE_HALF    = 2'b01;
    localparam logic [1:0] DSIZE_WORD    = 2'b10;
    localparam logic [1:0] DSIZE_INVALID = 2'b11;

    // Wide enough for any realistic channel count; the arbiter
    // zero-extends its channel index into this field.
    localparam int unsigned ARB_ID_W = 8;

    typedef struct packed {
        logic [ARB_ID_W-1:0] id;
        logic [1:0]          size;
`ifdef UDMA_TX_ARB_ALIGN_EN
        logic [1:0]          lsb;
`endif
    } arb_fifo_entry_t;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            DSIZE_BYTE: return 32'h0000_00FF;
            DSIZE_HALF: return 32'h0000_FFFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/udma_tx_arbiter_if.sv
// udma_tx_arbiter_if
//   Bundles the channel-side and L2-side signals of udma_tx_arbiter.
//   slave  : arbiter view (channel requests / L2 responses in)
//   master : environment view (address generators + L2 model)
//   Signals:
//     ch_req_i, ch_addr_i, ch_datasize_i  channel request side
//     ch_gnt_o, not_stall_o               back to the address generators
//     l2_req_o, l2_addr_o, l2_gnt_i       L2 read request handshake
//     l2_rvalid_i, l2_rdata_i             L2 in-order read response
//     ch_rvalid_o, ch_rdata_o, ch_rsize_o routed response per channel
interface udma_tx_arbiter_if #(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned L2_AWIDTH_NOAL = 18
) ();

    logic [N_CHANNELS-1:0]                     ch_req_i;
    logic [N_CHANNELS-1:0][L2_AWIDTH_NOAL-1:0] ch_addr_i;
    logic [N_CHANNELS-1:0][1:0]                ch_datasize_i;
    logic [N_CHANNELS-1:0]                     ch_gnt_o;
    logic                                      not_stall_o;
    logic                                      l2_req_o;
    logic [31:0]                               l2_addr_o;
    logic                                      l2_gnt_i;
    logic                                      l2_rvalid_i;
    logic [31:0]                               l2_rdata_i;
    logic [N_CHANNELS-1:0]                     ch_rvalid_o;
    logic [31:0]                               ch_rdata_o;
    logic [1:0]                                ch_rsize_o;

    modport slave (
        input  ch_req_i, ch_addr_i, ch_datasize_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        output ch_gnt_o, not_stall_o, l2_req_o, l2_addr_o, ch_rvalid_o, ch_rdata_o, ch_rsize_o
    );

    modport master (
        output ch_req_i, ch_addr_i, ch_datasize_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        input  ch_gnt_o, not_stall_o, l2_req_o, l2_addr_o, ch_rvalid_o, ch_rdata_o, ch_rsize_o
    );

endinterface

// File: rtl/udma_arb_fifo.sv
// udma_arb_fifo
//   Generic synchronous FIFO, parameterised on depth (power of two, >= 2)
//   and entry type. Synchronous active-low reset.
//   Ports:
//     i_clk, i_rstn      clock / reset
//     i_push, i_data     write side (ignored when full and not popping)
//     i_pop, o_data      read side; o_data shows the head entry
//     o_full, o_empty    status
//     o_occupancy        number of stored entries
module udma_arb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_occupancy = r_count;
    assign o_data      = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    // A push into a full FIFO is still accepted when the head leaves
    // in the same cycle.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/udma_tx_arbiter.sv
// udma_tx_arbiter
//   Round-robin arbiter between N TX address generators and the L2 read
//   port. Latches one winner at a time into a request register, issues it
//   to L2, tracks accepted reads in an in-order FIFO and routes each
//   response back to its channel.
//   Ports:
//     clk_i, rstn_i   clock, synchronous active-low reset
//     bus (slave)     channel request/grant, L2 request/response,
//                     per-channel response (see udma_tx_arbiter_if)
//   Optional feature macro: UDMA_TX_ARB_ALIGN_EN -- when defined the
//   response is shifted by the byte offset and masked to the data size;
//   otherwise the L2 data is passed through unmodified.
module udma_tx_arbiter
    import udma_arb_pkg::*;
#(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned L2_AWIDTH_NOAL = 18,
    parameter int unsigned OUTSTANDING    = 4,
    parameter logic [31:0] L2_BASE        = 32'h1C00_0000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    udma_tx_arbiter_if.slave  bus
);

    localparam int unsigned IDW = $clog2(N_CHANNELS);
    localparam int unsigned CW  = $clog2(OUTSTANDING) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [31:0]      r_l2_addr;
    arb_fifo_entry_t  r_req_entry;

    logic [N_CHANNELS-1:0] w_elig;
    logic [N_CHANNELS-1:0] w_gnt;
    logic [N_CHANNELS-1:0] w_rvalid;
    logic                  w_found;
    logic [IDW-1:0]        w_winner;
    logic                  w_drain;
    logic                  w_room;
    logic                  w_latch;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_occ;
    logic [31:0]           w_addr_ext;
    logic [31:0]           w_rdata;
    arb_fifo_entry_t       w_new_entry;
    arb_fifo_entry_t       w_head;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        assign w_elig[g]   = bus.ch_req_i[g] && (bus.ch_datasize_i[g] != DSIZE_INVALID);
        assign w_gnt[g]    = w_latch && (w_winner == IDW'(g));
        assign w_rvalid[g] = w_pop && (w_head.id == ARB_ID_W'(g));
    end

    // First eligible channel at or above the round-robin pointer, with wrap.
    always_comb begin : p_arb
        int unsigned idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int unsigned k = 0; k < N_CHANNELS; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= N_CHANNELS) begin
                idx = idx - N_CHANNELS;
            end
            if (!w_found && w_elig[IDW'(idx)]) begin
                w_found  = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    assign w_drain = (r_state == ST_REQ) && bus.l2_gnt_i;
    // Room is judged against the push landing this cycle only; a pop in
    // the same cycle frees space for the following cycle.
    assign w_room  = (32'(w_occ) + 32'(w_drain)) < OUTSTANDING;
    // Gated by reset so the grant outputs read zero while held in reset.
    assign w_latch = rstn_i && w_found && ((r_state == ST_IDLE) || w_drain) && w_room;

    always_comb begin
        w_addr_ext      = 32'(bus.ch_addr_i[w_winner]);
        w_addr_ext[1:0] = 2'b00;
    end

    always_comb begin
        w_new_entry      = '0;
        w_new_entry.id   = ARB_ID_W'(w_winner);
        w_new_entry.size = bus.ch_datasize_i[w_winner];
`ifdef UDMA_TX_ARB_ALIGN_EN
        w_new_entry.lsb  = bus.ch_addr_i[w_winner][1:0];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_l2_addr   <= '0;
            r_req_entry <= '0;
        end else begin
            if (w_latch) begin
                r_state     <= ST_REQ;
                r_rr_ptr    <= (w_winner == IDW'(N_CHANNELS - 1)) ? '0 : w_winner + IDW'(1);
                r_l2_addr   <= L2_BASE | w_addr_ext;
                r_req_entry <= w_new_entry;
            end else if (w_drain) begin
                r_state <= ST_IDLE;
            end
        end
    end

    udma_arb_fifo #(
        .DEPTH (OUTSTANDING),
        .T     (arb_fifo_entry_t)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rstn      (rstn_i),
        .i_push      (w_drain),
        .i_data      (r_req_entry),
        .i_pop       (bus.l2_rvalid_i),
        .o_data      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_occupancy (w_occ)
    );

    // A response with nothing outstanding is dropped.
    assign w_pop = bus.l2_rvalid_i && !w_empty;

    always_comb begin
        w_rdata = '0;
        if (w_pop) begin
`ifdef UDMA_TX_ARB_ALIGN_EN
            w_rdata = (bus.l2_rdata_i >> {w_head.lsb, 3'b000}) & size_mask(w_head.size);
`else
            w_rdata = bus.l2_rdata_i;
`endif
        end
    end

    assign bus.ch_gnt_o    = w_gnt;
    assign bus.not_stall_o = !w_full;
    assign bus.l2_req_o    = (r_state == ST_REQ);
    assign bus.l2_addr_o   = r_l2_addr;
    assign bus.ch_rvalid_o = w_rvalid;
    assign bus.ch_rdata_o  = w_rdata;
    assign bus.ch_rsize_o  = w_pop ? w_head.size : 2'b00;

endmodule

// File: doc/udma_tx_arbiter.md
# udma_tx_arbiter

Round-robin read-request arbiter sitting directly downstream of the per-channel uDMA address generators on the TX path. It collects the current address and data size from N enabled channels and issues one-at-a-time L2 read requests. It pulses a grant back to the winning channel's address generator, which makes that generator advance its address and counter. It also tracks outstanding reads in order and routes each aligned read response back to the channel that issued it.

## Interface
- `N_CHANNELS`, 4: number of TX channels arbitrated, ≥2.
- `L2_AWIDTH_NOAL`, 18: width of the channel byte address.
- `OUTSTANDING`, 4: maximum in-flight L2 reads, power of two.
- `L2_BASE`, 32'h1C00_0000: OR-ed into the upper bits of `l2_addr_o`.

Ports:
- `clk_i`, in, 1: clock.
- `rstn_i`, in, 1: reset. One clock; reset is synchronous and active-low.
- `ch_req_i`, in, N_CHANNELS: channel enabled and requesting; driven by the address generator's enable output.
- `ch_addr_i`, in, N_CHANNELS×L2_AWIDTH_NOAL: current byte address per channel.
- `ch_datasize_i`, in, N_CHANNELS×2: 00 = byte, 01 = half, 10 = word, 11 = invalid.
- `ch_gnt_o`, out, N_CHANNELS: one-hot, single-cycle grant to the address generator.
- `not_stall_o`, out, 1: high when the outstanding FIFO is not full.
- `l2_req_o`, out, 1: L2 read request.
- `l2_addr_o`, out, 32: word-aligned L2 address.
- `l2_gnt_i`, in, 1: L2 accepts the request.
- `l2_rvalid_i`, in, 1: read data valid; responses return in order.
- `l2_rdata_i`, in, 32: read data.
- `ch_rvalid_o`, out, N_CHANNELS: one-hot response valid per channel.
- `ch_rdata_o`, out, 32: response data, shared by all channels.
- `ch_rsize_o`, out, 2: data size of the current response.

## Operation
- **Eligible channel:** `ch_req_i[i]` is high and `ch_datasize_i[i]` is not 11. Channels with size 11 are never granted.
- **Arbitration:**
  - Winner = first eligible channel at or after the round-robin pointer `rr_ptr`, searching upward with wrap.
  - After every grant, `rr_ptr` = winner + 1, wrapping to 0 past N_CHANNELS−1.
- **Request register:** one entry holding {addr, channel id, size, addr[1:0]}.
- **Latching:** a new winner is latched, and `ch_gnt_o[winner]` pulses in the same cycle, when all of the following hold:
  - an eligible channel exists;
  - the request register is empty, or is being drained this cycle (`l2_req_o && l2_gnt_i`);
  - the outstanding FIFO is not full, counting the push happening this cycle.
- **FSM, 2 states:**
  - IDLE → REQ on latch.
  - REQ → IDLE on `l2_gnt_i` when no new latch happens.
  - REQ → REQ on `l2_gnt_i` with a back-to-back latch.
  - `l2_req_o` = (state == REQ).
- **Address:** `l2_addr_o` = `L2_BASE` | {zero-extended latched addr with bits [1:0] forced to 0}. It is held stable while `l2_req_o` is high and not granted.
- **FIFO push:** on an L2 handshake, push {id, size, addr[1:0]} into the outstanding FIFO.
- **FIFO pop:** on `l2_rvalid_i`, pop the FIFO and assert `ch_rvalid_o[id]` in the same cycle (combinational route).
- **Response data:** `ch_rdata_o` = `l2_rdata_i` >> (8 × addr[1:0]), masked to the size width (8, 16 or 32 bits, upper bits zero). `ch_rsize_o` = stored size.
- **Simultaneous push and pop:** FIFO occupancy is unchanged.
- **`l2_rvalid_i` while the FIFO is empty:** protocol error. The data is ignored, no `ch_rvalid_o` is raised, and the occupancy stays at 0.
- **Empty FIFO:** all `ch_rvalid_o` low.
- **Channel deasserts `ch_req_i` while its request sits in REQ:** the request still completes and the response is still delivered.
- **Reset mid-operation:** in-flight L2 transactions are dropped. The integration guarantees the L2 side is idle across reset.

## Timing
- **Reset values:** `ch_gnt_o` = 0, `not_stall_o` = 1, `l2_req_o` = 0, `l2_addr_o` = 0, `ch_rvalid_o` = 0, `ch_rdata_o` = 0, `ch_rsize_o` = 0. Internally `rr_ptr` = 0, state = IDLE, FIFO empty.
- **Request latency:** grant in cycle T; `l2_req_o` is high from T+1.
- **Sustained throughput:** 1 request per cycle when `l2_gnt_i` is held high and the FIFO has room.
- **Response latency:** 0 cycles from `l2_rvalid_i` to `ch_rvalid_o`.
- **`not_stall_o`:** registered, equal to occupancy < OUTSTANDING. It feeds the address generators' not-stall input.

## Configuration
- `UDMA_TX_ARB_ALIGN_EN` defined: the byte-lane shifter and size masking are compiled in, as described under Operation.
- Undefined: `ch_rdata_o` = `l2_rdata_i` unmodified, and addr[1:0] is not stored in the FIFO, which narrows the entry.

## Structure
- Package `udma_arb_pkg`:
  - datasize encoding constants (`DSIZE_BYTE`, `DSIZE_HALF`, `DSIZE_WORD`);
  - typedef `arb_fifo_entry_t` {id, size, [lsb]};
  - helper `function` for the size mask.
- Sub-module `udma_arb_fifo`: generic synchronous FIFO parameterised on depth and entry type, with full, empty and occupancy outputs. The arbiter instantiates it once.

## Test plan
- **Single channel:** ch0 requests byte reads from address 0x0003 with `l2_gnt_i` held at 1.
  - `ch_gnt_o` = 0001 every cycle; `l2_addr_o` = 0x1C000000.
  - A response of 0xAABBCCDD gives `ch_rdata_o` = 0x000000AA.
- **Round robin:** ch0–ch3 all request with `l2_gnt_i` = 1. The grant order is 0, 1, 2, 3, 0, with exactly one grant per cycle.
- **L2 backpressure:** `l2_gnt_i` = 0 for 5 cycles while ch1 requests word address 0x100.
  - `l2_req_o` stays high with `l2_addr_o` = 0x1C000100.
  - Exactly one grant to ch1, and no second latch until L2 accepts.
- **FIFO full:** OUTSTANDING = 4 handshakes with no `l2_rvalid_i`.
  - `not_stall_o` falls, and `ch_gnt_o` stays 0.
  - One `l2_rvalid_i` re-enables granting on the next cycle.
- **In-order routing:** requests issued ch2, ch0, ch2, with a half-word at address 0x2.
  - The responses assert `ch_rvalid_o` = 0100, 0001, 0100 in that order.
  - The half-word response of 0x12345678 gives 0x00001234.
- **Invalid size and reset:** ch3 has size 11 while ch1 requests.
  - ch3 is never granted.
  - Asserting `rstn_i` low mid-burst clears every output to its reset value on the next edge.
